// File: rtl/tmds_dec.sv
// tmds_dec: TMDS lane bit-slip aligner and symbol decoder.
// Define TMDS_DEC_LOSS_CNT_EN to add the saturating LOSS_CNT_o lock-loss counter.
module tmds_dec #(
  parameter int LOCK_RUN     = 8,
  parameter int SEARCH_WIN   = 1024,
  parameter int MAX_DATA_RUN = 4095
) (
  input  logic       CK,
  input  logic       XAR,
  input  logic       CKE_i,
  input  logic [9:0] SYM_i,
  output logic [7:0] D_o,
  output logic       DE_o,
  output logic       C0_o,
  output logic       C1_o,
  output logic       LOCK_o,
  output logic [3:0] SLIP_o
`ifdef TMDS_DEC_LOSS_CNT_EN
  ,
  output logic [7:0] LOSS_CNT_o
`endif
);
  typedef enum logic {SEARCH, LOCKED} state_t;
  state_t state;
  logic [9:0] prev;
  logic [9:0] wd;
  logic [11:0] wcnt;
  logic [11:0] dcnt;
  logic [7:0] run;
  logic tok;
  logic [1:0] ctl;
  logic [7:0] d;
  logic [7:0] pix;
  logic [3:0] slip_nx;
  always_comb begin
    wd = 10'({SYM_i, prev} >> SLIP_o);
    tok = wd == 10'b1101010100 || wd == 10'b0010101011 ||
          wd == 10'b0101010100 || wd == 10'b1010101011;
    ctl = {wd == 10'b0101010100 || wd == 10'b1010101011,
           wd == 10'b0010101011 || wd == 10'b1010101011};
    d = wd[9] ? ~wd[7:0] : wd[7:0];
    pix = {wd[8] ? d[7:1] ^ d[6:0] : ~(d[7:1] ^ d[6:0]), d[0]};
    slip_nx = SLIP_o == 4'd9 ? 4'd0 : SLIP_o + 4'd1;
  end
  always_ff @(posedge CK) begin
    if (!XAR) begin
      state <= SEARCH;
      prev <= '0;
      D_o <= '0;
      DE_o <= 1'b0;
      C0_o <= 1'b0;
      C1_o <= 1'b0;
      LOCK_o <= 1'b0;
      SLIP_o <= '0;
      wcnt <= '0;
      dcnt <= '0;
      run <= '0;
`ifdef TMDS_DEC_LOSS_CNT_EN
      LOSS_CNT_o <= '0;
`endif
    end else if (CKE_i) begin
      prev <= SYM_i;
      DE_o <= !tok;
      if (tok) {C1_o, C0_o} <= ctl;
      else D_o <= pix;
      if (state == SEARCH) begin
        wcnt <= wcnt + 12'd1;
        run <= tok ? run + 8'd1 : 8'd0;
        // lock takes priority over a window expiring on the same edge
        if (tok && run == 8'(LOCK_RUN - 1)) begin
          state <= LOCKED;
          LOCK_o <= 1'b1;
          run <= '0;
          dcnt <= '0;
        end else if (wcnt == 12'(SEARCH_WIN - 1)) begin
          SLIP_o <= slip_nx;
          wcnt <= '0;
          run <= '0;
        end
      end else begin
        dcnt <= tok ? 12'd0 : dcnt + 12'd1;
        if (!tok && dcnt == 12'(MAX_DATA_RUN - 1)) begin
          state <= SEARCH;
          LOCK_o <= 1'b0;
          SLIP_o <= slip_nx;
          wcnt <= '0;
          run <= '0;
`ifdef TMDS_DEC_LOSS_CNT_EN
          if (LOSS_CNT_o != 8'hFF) LOSS_CNT_o <= LOSS_CNT_o + 8'd1;
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_tmds_dec.sv
// tb_tmds_dec: table-driven and randomized checks of tmds_dec against a serial-stream reference model.
module tb_tmds_dec;
  localparam int LOCK_RUN = 8;
  localparam int SEARCH_WIN = 1024;
  localparam int MAX_DATA_RUN = 4095;
  logic CK = 1'b0;
  logic XAR = 1'b0;
  logic CKE_i = 1'b0;
  logic [9:0] SYM_i = '0;
  logic [7:0] D_o;
  logic DE_o, C0_o, C1_o, LOCK_o;
  logic [3:0] SLIP_o;
`ifdef TMDS_DEC_LOSS_CNT_EN
  logic [7:0] LOSS_CNT_o;
`endif
  tmds_dec #(.LOCK_RUN(LOCK_RUN), .SEARCH_WIN(SEARCH_WIN), .MAX_DATA_RUN(MAX_DATA_RUN)) dut (
    .CK(CK), .XAR(XAR), .CKE_i(CKE_i), .SYM_i(SYM_i),
    .D_o(D_o), .DE_o(DE_o), .C0_o(C0_o), .C1_o(C1_o), .LOCK_o(LOCK_o), .SLIP_o(SLIP_o)
`ifdef TMDS_DEC_LOSS_CNT_EN
    , .LOSS_CNT_o(LOSS_CNT_o)
`endif
  );
  always #5 CK = ~CK;
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  int errors = 0;
  int checks = 0;
  logic [9:0] tok_tab [4];
  int disp = 0;
  int off = 0;
  logic [9:0] tx_prev = '0;
  // reference model state, advanced once per enabled edge
  logic [9:0] m_prev;
  int m_slip, m_wc, m_run, m_dc, m_loss;
  bit m_lock, m_de, m_c0, m_c1;
  logic [7:0] m_d;
  typedef struct {
    logic [9:0] sym;
    logic [7:0] d;
    logic de;
    logic [1:0] c;
  } vec_t;
  vec_t tbl [9];
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [9:0] enc(input logic [7:0] v);
    logic [8:0] qm;
    logic [9:0] q;
    int n1, nq1, nq0;
    bit xn;
    n1 = $countones(v);
    xn = n1 > 4 || (n1 == 4 && !v[0]);
    qm[0] = v[0];
    for (int i = 1; i < 8; i++) qm[i] = xn ? ~(qm[i-1] ^ v[i]) : qm[i-1] ^ v[i];
    qm[8] = !xn;
    nq1 = $countones(qm[7:0]);
    nq0 = 8 - nq1;
    if (disp == 0 || nq1 == nq0) begin
      q = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      disp += qm[8] ? nq1 - nq0 : nq0 - nq1;
    end else if ((disp > 0 && nq1 > nq0) || (disp < 0 && nq0 > nq1)) begin
      q = {1'b1, qm[8], ~qm[7:0]};
      disp += (qm[8] ? 2 : 0) + nq0 - nq1;
    end else begin
      q = {1'b0, qm[8], qm[7:0]};
      disp += (qm[8] ? 0 : -2) + nq1 - nq0;
    end
    return q;
  endfunction
  function automatic logic [7:0] dec(input logic [9:0] w);
    logic [7:0] q, r;
    q = w[9] ? ~w[7:0] : w[7:0];
    r[0] = q[0];
    for (int i = 1; i < 8; i++) r[i] = q[i] ^ q[i-1] ^ ~w[8];
    return r;
  endfunction
  task automatic m_reset();
    m_prev = '0; m_slip = 0; m_wc = 0; m_run = 0; m_dc = 0; m_loss = 0;
    m_lock = 0; m_de = 0; m_c0 = 0; m_c1 = 0; m_d = '0;
  endtask
  task automatic m_step(input logic [9:0] s);
    logic [19:0] w;
    logic [9:0] wd;
    int k;
    w = {s, m_prev};
    wd = w[m_slip +: 10];
    k = -1;
    for (int i = 0; i < 4; i++) if (wd == tok_tab[i]) k = i;
    if (k >= 0) begin
      m_de = 0;
      m_c1 = k[1];
      m_c0 = k[0];
    end else begin
      m_de = 1;
      m_d = dec(wd);
    end
    if (!m_lock) begin
      m_run = k >= 0 ? m_run + 1 : 0;
      m_wc++;
      if (m_run == LOCK_RUN) begin
        m_lock = 1; m_run = 0; m_dc = 0;
      end else if (m_wc == SEARCH_WIN) begin
        m_slip = (m_slip + 1) % 10; m_wc = 0; m_run = 0;
      end
    end else begin
      m_dc = k >= 0 ? 0 : m_dc + 1;
      if (m_dc == MAX_DATA_RUN) begin
        m_lock = 0; m_slip = (m_slip + 1) % 10; m_wc = 0; m_run = 0;
        if (m_loss < 255) m_loss++;
      end
    end
    m_prev = s;
  endtask
  task automatic step(input logic [9:0] s, input logic cke, input logic rn);
    @(negedge CK);
    SYM_i = s;
    CKE_i = cke;
    XAR = rn;
    @(posedge CK);
    #1;
    if (!rn) m_reset();
    else if (cke) m_step(s);
`ifdef TMDS_DEC_LOSS_CNT_EN
    check("model", {D_o, DE_o, C1_o, C0_o, LOCK_o, SLIP_o, LOSS_CNT_o},
          {m_d, m_de, m_c1, m_c0, m_lock, 4'(m_slip), 8'(m_loss)});
`else
    check("model", {D_o, DE_o, C1_o, C0_o, LOCK_o, SLIP_o},
          {m_d, m_de, m_c1, m_c0, m_lock, 4'(m_slip)});
`endif
  endtask
  // serialise the true symbol stream and re-cut it 'off' bits late
  task automatic send_true(input logic [9:0] t);
    logic [9:0] raw;
    raw = 10'({t, tx_prev} >> (10 - off));
    tx_prev = t;
    step(raw, 1'b1, 1'b1);
  endtask
  task automatic run_table();
    for (int i = 0; i < 9; i++) begin
      send_true(tbl[i].sym);
      if (i > 0) check("table", {D_o, DE_o, C1_o, C0_o}, {tbl[i-1].d, tbl[i-1].de, tbl[i-1].c});
    end
    send_true(tok_tab[0]);
    check("table", {D_o, DE_o, C1_o, C0_o}, {tbl[8].d, tbl[8].de, tbl[8].c});
    check("table_slip", SLIP_o, off);
  endtask
  task automatic wait_lock(input int start, input int exp_n);
    int n;
    n = start;
    while (!LOCK_o && n < 12000) begin
      send_true(tok_tab[0]);
      n++;
    end
    check("lock_edge", n, exp_n);
    check("lock_slip", SLIP_o, off);
  endtask
  initial begin
    logic [7:0] vals [5];
    tok_tab[0] = 10'b1101010100;
    tok_tab[1] = 10'b0010101011;
    tok_tab[2] = 10'b0101010100;
    tok_tab[3] = 10'b1010101011;
    vals[0] = 8'h00; vals[1] = 8'hFF; vals[2] = 8'h55; vals[3] = 8'hA5; vals[4] = 8'h10;
    for (int i = 0; i < 5; i++) tbl[i] = '{enc(vals[i]), vals[i], 1'b1, 2'b00};
    for (int i = 1; i < 4; i++) tbl[4 + i] = '{tok_tab[i], 8'h10, 1'b0, 2'(i)};
    tbl[8] = '{tok_tab[0], 8'h10, 1'b0, 2'b00};
    m_reset();
    step(10'h3FF, 1'b1, 1'b0);
    step(10'h3FF, 1'b1, 1'b0);
    check("reset", {D_o, DE_o, C0_o, C1_o, LOCK_o, SLIP_o}, '0);
    for (int i = 0; i < 20; i++) step(10'($urandom), 1'b0, 1'b1);
    check("hold", {D_o, DE_o, C0_o, C1_o, LOCK_o, SLIP_o}, '0);
    for (int i = 1; i <= 16; i++) begin
      send_true(tok_tab[0]);
      if (i == 8) check("lock_after_7", LOCK_o, 1'b0);
      if (i == 9) check("lock_after_8", LOCK_o, 1'b1);
    end
    check("aligned_slip", SLIP_o, 4'd0);
    run_table();
    for (int j = 1; j <= 4096; j++) begin
      send_true(enc(8'($urandom)));
      if (j == 4095) check("loss_before", LOCK_o, 1'b1);
    end
    check("loss_lock", LOCK_o, 1'b0);
    check("loss_slip", SLIP_o, 4'd1);
`ifdef TMDS_DEC_LOSS_CNT_EN
    check("loss_cnt", LOSS_CNT_o, 8'd1);
`endif
    foreach (vals[k]) begin
      if (k > 1) break;
      off = k == 0 ? 3 : 9;
      tx_prev = '0;
      step(10'h000, 1'b1, 1'b0);
      wait_lock(0, off * SEARCH_WIN + LOCK_RUN);
      run_table();
    end
    off = 3;
    step(10'h000, 1'b1, 1'b0);
    wait_lock(0, 3 * SEARCH_WIN + LOCK_RUN);
    step(10'h3FF, 1'b1, 1'b0);
    check("midreset", {LOCK_o, SLIP_o}, 5'd0);
    for (int i = 0; i < 100; i++) send_true(tok_tab[0]);
    check("no_early_relock", LOCK_o, 1'b0);
    wait_lock(100, 3 * SEARCH_WIN + LOCK_RUN);
    off = 0;
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [9:0] s;
      r = $urandom_range(0, 9);
      s = r < 6 ? tok_tab[$urandom_range(0, 3)] : r < 9 ? enc(8'($urandom)) : 10'($urandom);
      step(s, $urandom_range(0, 9) != 0, $urandom_range(0, 499) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
